// File: rtl/i2c_master_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : i2c_master_seq_pkg
// Brief   : State encoding and SCL phase-point helpers for i2c_master_seq.
// Rev     : 1.0 - initial release
// ============================================================================
package i2c_master_seq_pkg;

    typedef logic [3:0] i2c_state_t;

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_start     = 4'd1;
    localparam logic [3:0] c_st_addr      = 4'd2;
    localparam logic [3:0] c_st_addr_ack  = 4'd3;
    localparam logic [3:0] c_st_write     = 4'd4;
    localparam logic [3:0] c_st_write_ack = 4'd5;
    localparam logic [3:0] c_st_read      = 4'd6;
    localparam logic [3:0] c_st_read_ack  = 4'd7;
    localparam logic [3:0] c_st_stop      = 4'd8;
    localparam logic [3:0] c_st_stop_hold = 4'd9;

    // SDA change point: middle of the SCL-low half
    function automatic int chg_pt(input int duty);
        return duty / 2;
    endfunction

    // Sample point: middle of the SCL-high half
    function automatic int smp_pt(input int div, input int duty);
        return (duty + div) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_master_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : i2c_master_seq_if
// Brief     : Command, data, status and pad/driver signals of i2c_master_seq.
// Rev       : 1.0 - initial release
// ============================================================================
interface i2c_master_seq_if #(
    parameter int DIV_LEN = 16
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [6:0]         cmd_addr;
    logic               cmd_rw;
    logic [7:0]         cmd_len;
    logic [7:0]         wr_data;
    logic               wr_valid;
    logic               wr_ready;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               busy;
    logic               done;
    logic               nack;
    logic               underflow;
    logic               clk_hold;
    logic [DIV_LEN-1:0] phase;
    logic               sda_i;
    logic               sda_o;
    logic               sda_t;

    // Host / pad side
    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_len, wr_data, wr_valid, phase, sda_i,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, nack, underflow,
        input  clk_hold, sda_o, sda_t
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_len, wr_data, wr_valid, phase, sda_i,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, nack, underflow,
        output clk_hold, sda_o, sda_t
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_seq_half_timer.sv
`default_nettype none
// ============================================================================
// Module : i2c_master_seq_half_timer
// Brief  : Loadable down-counter timing the START/STOP hold intervals.
// Rev    : 1.0 - initial release
// ============================================================================
module i2c_master_seq_half_timer #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  expired
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/i2c_master_seq.sv
`default_nettype none
// ============================================================================
// Module : i2c_master_seq
// Brief  : Byte-level I2C master sequencer: START, address, data with
//          ACK/NACK handling, STOP; follows an external SCL phase counter.
// Rev    : 1.0 - initial release
// ============================================================================
module i2c_master_seq
    import i2c_master_seq_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CLK_DUTY = CLK_DIV / 2,
    parameter int DIV_LEN  = 16
) (
    input  wire logic     clk,
    input  wire logic     rstn,
    i2c_master_seq_if.slave bus
);
    localparam logic [DIV_LEN-1:0] c_chg  = DIV_LEN'(chg_pt(CLK_DUTY));
    localparam logic [DIV_LEN-1:0] c_smp  = DIV_LEN'(smp_pt(CLK_DIV, CLK_DUTY));
    localparam logic [DIV_LEN-1:0] c_half = DIV_LEN'(CLK_DIV / 2 - 1);

    i2c_state_t  r_state;
    logic [7:0]  r_shift;
    logic [7:0]  r_len;
    logic [7:0]  r_rd_data;
    logic [2:0]  r_bit;
    logic        r_rw;
    logic        r_done;
    logic        r_nack;
    logic        r_unf;
    logic        r_wr_ready;
    logic        r_rd_valid;
    logic        r_hold;
    logic        r_sda_t;

    logic        w_chg;
    logic        w_smp;
    logic        w_idle;
    logic        w_timer_load;
    logic        w_timer_exp;

    assign w_chg        = (bus.phase == c_chg);
    assign w_smp        = (bus.phase == c_smp);
    assign w_idle       = (r_state == c_st_idle);
    assign w_timer_load = (w_idle && bus.cmd_valid) || ((r_state == c_st_stop) && w_smp);

    i2c_master_seq_half_timer #(
        .WIDTH (DIV_LEN)
    ) u_half_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_timer_load),
        .load_val (c_half),
        .expired  (w_timer_exp)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_st_idle;
            r_shift    <= '0;
            r_len      <= '0;
            r_rd_data  <= '0;
            r_bit      <= '0;
            r_rw       <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_unf      <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_hold     <= 1'b1;
            r_sda_t    <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.cmd_valid) begin
                        r_shift <= {bus.cmd_addr, bus.cmd_rw};
                        r_rw    <= bus.cmd_rw;
                        r_len   <= bus.cmd_len;
                        r_nack  <= 1'b0;
                        r_unf   <= 1'b0;
                        r_bit   <= '0;
                        r_sda_t <= 1'b0;
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_timer_exp) begin
                        r_hold  <= 1'b0;
                        r_state <= c_st_addr;
                    end
                end
                c_st_addr, c_st_write: begin
                    if (w_chg) r_sda_t <= r_shift[7];
                    if (w_smp) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= (r_state == c_st_addr) ? c_st_addr_ack : c_st_write_ack;
                    end
                end
                c_st_addr_ack, c_st_write_ack: begin
                    if (w_chg) r_sda_t <= 1'b1;
                    // Next write byte is prefetched here so it is ready at the next CHG
                    if (w_smp) begin
                        if (bus.sda_i) begin
                            r_nack  <= 1'b1;
                            r_state <= c_st_stop;
                        end else if (r_len == 8'd0) begin
                            r_state <= c_st_stop;
                        end else if (r_rw) begin
                            r_state <= c_st_read;
                        end else if (bus.wr_valid) begin
                            r_shift    <= bus.wr_data;
                            r_wr_ready <= 1'b1;
                            r_len      <= r_len - 8'd1;
                            r_state    <= c_st_write;
                        end else begin
                            r_unf   <= 1'b1;
                            r_state <= c_st_stop;
                        end
                    end
                end
                c_st_read: begin
                    if (w_chg) r_sda_t <= 1'b1;
                    if (w_smp) begin
                        r_shift <= {r_shift[6:0], bus.sda_i};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rd_data  <= {r_shift[6:0], bus.sda_i};
                            r_rd_valid <= 1'b1;
                            r_len      <= r_len - 8'd1;
                            r_state    <= c_st_read_ack;
                        end
                    end
                end
                c_st_read_ack: begin
                    if (w_chg) r_sda_t <= (r_len == 8'd0);
                    if (w_smp) r_state <= (r_len == 8'd0) ? c_st_stop : c_st_read;
                end
                c_st_stop: begin
                    if (w_chg) r_sda_t <= 1'b0;
                    if (w_smp) begin
                        r_hold  <= 1'b1;
                        r_state <= c_st_stop_hold;
                    end
                end
                c_st_stop_hold: begin
                    if (w_timer_exp) begin
                        r_sda_t <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.cmd_ready = w_idle;
    assign bus.busy      = !w_idle;
    assign bus.done      = r_done;
    assign bus.nack      = r_nack;
    assign bus.underflow = r_unf;
    assign bus.wr_ready  = r_wr_ready;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.clk_hold  = r_hold;
    assign bus.sda_o     = 1'b0;
    assign bus.sda_t     = r_sda_t;
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_i2c_master_seq
// Brief  : Self-checking bench with SCL driver model and I2C slave model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_seq;
    localparam int CLK_DIV  = 8;
    localparam int CLK_DUTY = 4;
    localparam int DIV_LEN  = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    i2c_master_seq_if #(.DIV_LEN(DIV_LEN)) bus ();

    i2c_master_seq #(
        .CLK_DIV  (CLK_DIV),
        .CLK_DUTY (CLK_DUTY),
        .DIV_LEN  (DIV_LEN)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // SCL clock-driver model: phase held at 0 while clk_hold
    always @(posedge clk) begin
        if (!rstn || bus.clk_hold === 1'b1)
            bus.phase <= '0;
        else if (bus.phase == DIV_LEN'(CLK_DIV - 1))
            bus.phase <= '0;
        else
            bus.phase <= bus.phase + 1'b1;
    end

    logic slave_pull = 1'b0;
    assign bus.sda_i = bus.sda_t & ~slave_pull;

    int total = 0;
    int bad   = 0;

    // slave / monitor state, only touched from tick()
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    bit         in_xfer  = 1'b0;
    int         bit_idx  = 0;
    int         byte_idx = 0;
    bit         is_read  = 1'b0;
    bit         mnack    = 1'b0;
    logic [7:0] cur      = 8'h00;
    bit         ack_addr = 1'b1;
    bit         ack_data = 1'b1;
    int         frames = 0, start_cnt = 0, stop_cnt = 0;
    int         wr_rdy_cnt = 0, rd_vld_cnt = 0, done_cnt = 0;
    logic       done_nack = 1'b0, done_unf = 1'b0;

    logic [7:0] rd_src[$];
    logic [7:0] wr_q[$];
    logic [7:0] obs_bytes[$];
    logic [7:0] obs_rd[$];
    logic       obs_mack[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_rd[$];
    logic       exp_mack[$];

    task automatic tick();
        logic       scl, sda;
        logic [7:0] b;
        @(negedge clk);
        scl = bus.clk_hold | (bus.phase > DIV_LEN'(CLK_DUTY));
        sda = bus.sda_i;
        if (scl && prev_scl && prev_sda && !sda) begin
            start_cnt++; in_xfer = 1'b1; bit_idx = 0; byte_idx = 0;
            cur = 8'h00; is_read = 1'b0; mnack = 1'b0; slave_pull = 1'b0;
        end else if (scl && prev_scl && !prev_sda && sda) begin
            stop_cnt++; in_xfer = 1'b0; slave_pull = 1'b0;
        end else if (in_xfer && scl && !prev_scl) begin
            if (bit_idx < 8) begin
                cur = {cur[6:0], sda};
                bit_idx++;
            end else begin
                if (byte_idx == 0 || !is_read) begin
                    obs_bytes.push_back(cur);
                    if (byte_idx == 0) is_read = cur[0];
                end else begin
                    obs_mack.push_back(sda);
                    mnack = sda;
                end
                frames++; byte_idx++; bit_idx = 0;
            end
        end else if (in_xfer && !scl && prev_scl) begin
            if (bit_idx == 8) begin
                if (byte_idx == 0)   slave_pull = ack_addr;
                else if (!is_read)   slave_pull = ack_data;
                else                 slave_pull = 1'b0;
            end else if (is_read && byte_idx > 0 && !mnack && (byte_idx - 1) < rd_src.size()) begin
                b = rd_src[byte_idx-1];
                slave_pull = ~b[7-bit_idx];
            end else begin
                slave_pull = 1'b0;
            end
        end
        prev_scl = scl;
        prev_sda = sda;

        if (bus.wr_ready === 1'b1) begin
            wr_rdy_cnt++;
            if (wr_q.size() > 0) wr_q.delete(0);
        end
        bus.wr_valid = (wr_q.size() > 0);
        bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
        if (bus.rd_valid === 1'b1) begin
            rd_vld_cnt++;
            obs_rd.push_back(bus.rd_data);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_nack = bus.nack;
            done_unf  = bus.underflow;
        end
    endtask

    task automatic issue_cmd(input logic [6:0] addr, input logic rw, input logic [7:0] len);
        bus.cmd_addr  = addr;
        bus.cmd_rw    = rw;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.nack, bus.underflow, bus.wr_ready,
             bus.rd_valid, bus.clk_hold, bus.sda_t, bus.sda_o} !== 10'b1000000110) begin
            bad++;
            $display("FAIL reset_ctrl: rdy,busy,done,nack,unf,wrr,rdv,hold,sda_t,sda_o=%b%b%b%b%b%b%b%b%b%b required 1000000110",
                     bus.cmd_ready, bus.busy, bus.done, bus.nack, bus.underflow, bus.wr_ready,
                     bus.rd_valid, bus.clk_hold, bus.sda_t, bus.sda_o);
        end
        total++;
        if (bus.rd_data !== 8'h00) begin
            bad++; $display("FAIL reset_rd_data: got %02h required 00", bus.rd_data);
        end
        rstn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write();
        int wr0, fr0, st0, dn0;
        bit ok;
        logic [7:0] e, o;
        wr0 = wr_rdy_cnt; fr0 = frames; st0 = stop_cnt; dn0 = done_cnt;
        wr_q = '{8'hA5, 8'h3C};
        exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
        issue_cmd(7'h50, 1'b0, 8'd2);
        total++;
        if ({bus.sda_t, bus.busy, bus.cmd_ready} !== 3'b010) begin
            bad++; $display("FAIL accept_latency: sda_t,busy,rdy=%b%b%b required 010", bus.sda_t, bus.busy, bus.cmd_ready);
        end
        wait_done(1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL write_done: no done within budget, required done pulse"); end
        while (exp_bytes.size() > 0) begin
            e = exp_bytes.pop_front(); total++;
            if (obs_bytes.size() == 0) begin bad++; $display("FAIL write_byte: missing byte, required %02h", e); end
            else begin
                o = obs_bytes.pop_front();
                if (o !== e) begin bad++; $display("FAIL write_byte: got %02h required %02h", o, e); end
            end
        end
        repeat (3) tick();
        total++;
        if (wr_rdy_cnt - wr0 != 2) begin bad++; $display("FAIL write_wr_ready: got %0d pulses required 2", wr_rdy_cnt - wr0); end
        total++;
        if ({done_nack, done_unf} !== 2'b00) begin bad++; $display("FAIL write_status: nack,unf=%b%b required 00", done_nack, done_unf); end
        total++;
        if (frames - fr0 != 3 || stop_cnt - st0 != 1 || done_cnt - dn0 != 1) begin
            bad++; $display("FAIL write_framing: frames=%0d stops=%0d dones=%0d required 3 1 1", frames - fr0, stop_cnt - st0, done_cnt - dn0);
        end
        total++;
        if ({bus.busy, bus.cmd_ready, bus.clk_hold, bus.sda_t} !== 4'b0111) begin
            bad++; $display("FAIL write_idle: busy,rdy,hold,sda_t=%b%b%b%b required 0111", bus.busy, bus.cmd_ready, bus.clk_hold, bus.sda_t);
        end
    endtask

    task automatic test_addr_nack();
        int wr0, fr0, st0, s0;
        bit ok;
        logic [7:0] o;
        wr0 = wr_rdy_cnt; fr0 = frames; st0 = stop_cnt; s0 = start_cnt;
        ack_addr = 1'b0;
        wr_q = '{8'h11};
        issue_cmd(7'h50, 1'b0, 8'd1);
        repeat (30) tick();
        bus.cmd_valid = 1'b1;          // must be ignored while busy
        repeat (20) tick();
        bus.cmd_valid = 1'b0;
        wait_done(1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nack_done: no done within budget, required done pulse"); end
        repeat (20) tick();
        total++;
        if (done_nack !== 1'b1) begin bad++; $display("FAIL nack_flag: got %b required 1", done_nack); end
        total++;
        if (wr_rdy_cnt != wr0) begin bad++; $display("FAIL nack_wr_ready: got %0d pulses required 0", wr_rdy_cnt - wr0); end
        total++;
        if (frames - fr0 != 1 || stop_cnt - st0 != 1) begin
            bad++; $display("FAIL nack_framing: frames=%0d stops=%0d required 1 1", frames - fr0, stop_cnt - st0);
        end
        total++;
        if (start_cnt - s0 != 1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL busy_ignore: starts=%0d busy=%b required 1 0", start_cnt - s0, bus.busy);
        end
        total++;
        o = (obs_bytes.size() > 0) ? obs_bytes.pop_front() : 8'hxx;
        if (o !== 8'hA0) begin bad++; $display("FAIL nack_addr_byte: got %02h required a0", o); end
        ack_addr = 1'b1;
        wr_q.delete();
        obs_bytes.delete();
    endtask

    task automatic test_read();
        int fr0, rv0;
        bit ok;
        logic [7:0] e, o;
        logic em, om;
        fr0 = frames; rv0 = rd_vld_cnt;
        rd_src = '{8'h5A, 8'hC3};
        exp_bytes.push_back(8'hA3);
        exp_rd.push_back(8'h5A); exp_rd.push_back(8'hC3);
        exp_mack.push_back(1'b0); exp_mack.push_back(1'b1);
        issue_cmd(7'h51, 1'b1, 8'd2);
        wait_done(1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL read_done: no done within budget, required done pulse"); end
        while (exp_bytes.size() > 0) begin
            e = exp_bytes.pop_front(); total++;
            o = (obs_bytes.size() > 0) ? obs_bytes.pop_front() : 8'hxx;
            if (o !== e) begin bad++; $display("FAIL read_addr_byte: got %02h required %02h", o, e); end
        end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front(); total++;
            o = (obs_rd.size() > 0) ? obs_rd.pop_front() : 8'hxx;
            if (o !== e) begin bad++; $display("FAIL read_data: got %02h required %02h", o, e); end
        end
        while (exp_mack.size() > 0) begin
            em = exp_mack.pop_front(); total++;
            om = (obs_mack.size() > 0) ? obs_mack.pop_front() : 1'bx;
            if (om !== em) begin bad++; $display("FAIL read_master_ack: got %b required %b", om, em); end
        end
        total++;
        if (rd_vld_cnt - rv0 != 2 || frames - fr0 != 3 || done_nack !== 1'b0) begin
            bad++; $display("FAIL read_summary: rd_valid=%0d frames=%0d nack=%b required 2 3 0", rd_vld_cnt - rv0, frames - fr0, done_nack);
        end
        rd_src.delete();
    endtask

    task automatic test_underflow();
        int wr0, fr0, dn0;
        bit ok;
        logic [7:0] e, o;
        wr0 = wr_rdy_cnt; fr0 = frames; dn0 = done_cnt;
        wr_q = '{8'h77};
        exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'h77);
        issue_cmd(7'h50, 1'b0, 8'd3);
        wait_done(1500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL unf_done: no done within budget, required done pulse"); end
        while (exp_bytes.size() > 0) begin
            e = exp_bytes.pop_front(); total++;
            o = (obs_bytes.size() > 0) ? obs_bytes.pop_front() : 8'hxx;
            if (o !== e) begin bad++; $display("FAIL unf_byte: got %02h required %02h", o, e); end
        end
        total++;
        if ({done_unf, done_nack} !== 2'b10) begin bad++; $display("FAIL unf_flags: unf,nack=%b%b required 10", done_unf, done_nack); end
        total++;
        if (wr_rdy_cnt - wr0 != 1 || frames - fr0 != 2 || done_cnt - dn0 != 1) begin
            bad++; $display("FAIL unf_framing: wr_ready=%0d frames=%0d dones=%0d required 1 2 1", wr_rdy_cnt - wr0, frames - fr0, done_cnt - dn0);
        end
        obs_bytes.delete();
    endtask

    task automatic test_probe();
        int wr0, rv0, fr0, st0;
        bit ok;
        logic [7:0] o;
        wr0 = wr_rdy_cnt; rv0 = rd_vld_cnt; fr0 = frames; st0 = stop_cnt;
        exp_bytes.push_back(8'h78);
        issue_cmd(7'h3C, 1'b0, 8'd0);
        wait_done(1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL probe_done: no done within budget, required done pulse"); end
        total++;
        o = (obs_bytes.size() > 0) ? obs_bytes.pop_front() : 8'hxx;
        if (o !== exp_bytes[0]) begin bad++; $display("FAIL probe_byte: got %02h required %02h", o, exp_bytes[0]); end
        exp_bytes.delete();
        total++;
        if (frames - fr0 != 1 || stop_cnt - st0 != 1 || wr_rdy_cnt != wr0 || rd_vld_cnt != rv0 || done_nack !== 1'b0) begin
            bad++; $display("FAIL probe_framing: frames=%0d stops=%0d wr_ready=%0d rd_valid=%0d nack=%b required 1 1 0 0 0",
                            frames - fr0, stop_cnt - st0, wr_rdy_cnt - wr0, rd_vld_cnt - rv0, done_nack);
        end
    endtask

    task automatic test_reset_abort();
        int dn0;
        bit hit;
        dn0 = done_cnt;
        hit = 1'b0;
        wr_q = '{8'hA5, 8'h3C};
        issue_cmd(7'h50, 1'b0, 8'd2);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (in_xfer && byte_idx == 1 && bit_idx == 4) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL abort_reach: mid-byte point not reached, required reached"); end
        rstn = 1'b0;
        tick();
        total++;
        if ({bus.clk_hold, bus.sda_t, bus.busy, bus.cmd_ready} !== 4'b1101) begin
            bad++; $display("FAIL abort_release: hold,sda_t,busy,rdy=%b%b%b%b required 1101", bus.clk_hold, bus.sda_t, bus.busy, bus.cmd_ready);
        end
        rstn = 1'b1;
        repeat (5) tick();
        total++;
        if (done_cnt != dn0) begin bad++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt - dn0); end
        wr_q.delete();
        obs_bytes.delete();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 7'h00;
        bus.cmd_rw    = 1'b0;
        bus.cmd_len   = 8'h00;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_underflow();
        test_probe();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
